// File: rtl/mips_run_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_run_controller_if
// Description : Bundles the run-control, core-facing and trace read-port
//               signals of mips_run_controller. The slave modport is the
//               controller's view; master is the host/core side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_run_controller_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TRACE_AW   = 5,
    parameter int STEP_W     = 8
);
    // Run control
    logic                  start;
    logic                  abort;
    logic [DATA_WIDTH-1:0] startPc;
    logic [STEP_W-1:0]     numSteps;
    logic [DATA_WIDTH-1:0] haltPc;

    // mips_core connection
    logic [DATA_WIDTH-1:0] pcIn;
    logic [DATA_WIDTH-1:0] corePcOut;
    logic [DATA_WIDTH-1:0] coreResult;

    // Status
    logic                  busy;
    logic                  done;
    logic                  haltHit;
    logic                  overflow;
    logic [STEP_W-1:0]     stepsDone;

    // Trace read port
    logic [TRACE_AW-1:0]   rdAddr;
    logic [DATA_WIDTH-1:0] rdData;

    modport slave (
        input  start, abort, startPc, numSteps, haltPc,
        input  corePcOut, coreResult, rdAddr,
        output pcIn, busy, done, haltHit, overflow, stepsDone, rdData
    );

    modport master (
        output start, abort, startPc, numSteps, haltPc,
        output corePcOut, coreResult, rdAddr,
        input  pcIn, busy, done, haltHit, overflow, stepsDone, rdData
    );
endinterface
`default_nettype wire

// File: rtl/mips_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : mips_run_controller
// Description : Steps a mips_core by owning its PC register, feeding pcOut
//               back each cycle and recording every result into a trace
//               buffer. A run ends on step count, halt-PC match or abort;
//               the trace is read back through a registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_run_controller #(
    parameter int DATA_WIDTH  = 32,
    parameter int TRACE_DEPTH = 32,
    parameter int TRACE_AW    = 5,
    parameter int STEP_W      = 8
) (
    input  logic                  clock,
    input  logic                  resetN,
    mips_run_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [TRACE_AW-1:0] c_LAST_PTR  = TRACE_AW'(TRACE_DEPTH - 1);
    localparam logic [STEP_W-1:0]   c_STEP_MAX  = {STEP_W{1'b1}};
    localparam logic [31:0]         c_DEPTH_32  = 32'(TRACE_DEPTH);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_pcIn;
    logic [STEP_W-1:0]     r_stepsDone;
    logic [TRACE_AW-1:0]   r_wrPtr;
    logic                  r_haltHit;
    logic                  r_overflow;
    logic                  r_busy;
    logic                  r_done;
    logic [STEP_W-1:0]     r_numSteps;
    logic [DATA_WIDTH-1:0] r_haltPc;
    logic [DATA_WIDTH-1:0] r_rdData;
    logic [DATA_WIDTH-1:0] r_trace [TRACE_DEPTH];

    state_t                w_stateNext;
    logic [DATA_WIDTH-1:0] w_pcNext;
    logic [STEP_W-1:0]     w_stepsNext;
    logic [TRACE_AW-1:0]   w_wrPtrNext;
    logic                  w_haltHitNext;
    logic                  w_overflowNext;
    logic [STEP_W-1:0]     w_numStepsNext;
    logic [DATA_WIDTH-1:0] w_haltPcNext;
    logic                  w_wrEn;
    logic [STEP_W-1:0]     w_stepsInc;
    logic [31:0]           w_stepsWide;

    assign w_stepsInc  = r_stepsDone + STEP_W'(1);
    assign w_stepsWide = 32'(r_stepsDone);

    // Next-state and datapath decode: launch on start, step or abort in RUN.
    always_comb begin
        w_stateNext    = r_state;
        w_pcNext       = r_pcIn;
        w_stepsNext    = r_stepsDone;
        w_wrPtrNext    = r_wrPtr;
        w_haltHitNext  = r_haltHit;
        w_overflowNext = r_overflow;
        w_numStepsNext = r_numSteps;
        w_haltPcNext   = r_haltPc;
        w_wrEn         = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                // start beats a simultaneous abort; abort alone is ignored here
                if (bus.start) begin
                    w_numStepsNext = bus.numSteps;
                    w_haltPcNext   = bus.haltPc;
                    w_pcNext       = bus.startPc;
                    w_stepsNext    = '0;
                    w_wrPtrNext    = '0;
                    w_haltHitNext  = 1'b0;
                    w_overflowNext = 1'b0;
                    w_stateNext    = (bus.numSteps == '0) ? S_DONE : S_RUN;
                end
            end

            S_RUN: begin
                if (bus.abort) begin
                    // Abort freezes PC, count and trace exactly where they are
                    w_stateNext = S_DONE;
                end else begin
                    w_wrEn      = 1'b1;
                    w_pcNext    = bus.corePcOut;
                    w_stepsNext = (r_stepsDone == c_STEP_MAX) ? r_stepsDone : w_stepsInc;
                    // Pointer parks on the last entry; later steps overwrite it
                    if (r_wrPtr != c_LAST_PTR) begin
                        w_wrPtrNext = r_wrPtr + TRACE_AW'(1);
                    end
                    // This step is number stepsDone+1; beyond the depth it overflows
                    if (w_stepsWide >= c_DEPTH_32) begin
                        w_overflowNext = 1'b1;
                    end
                    // Halt match takes precedence so haltHit is set on a tie
                    if (bus.corePcOut == r_haltPc) begin
                        w_haltHitNext = 1'b1;
                        w_stateNext   = S_DONE;
                    end else if (w_stepsInc == r_numSteps) begin
                        w_stateNext   = S_DONE;
                    end
                end
            end

            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // State, control and status registers.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state     <= S_IDLE;
            r_pcIn      <= '0;
            r_stepsDone <= '0;
            r_wrPtr     <= '0;
            r_haltHit   <= 1'b0;
            r_overflow  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_numSteps  <= '0;
            r_haltPc    <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_pcIn      <= w_pcNext;
            r_stepsDone <= w_stepsNext;
            r_wrPtr     <= w_wrPtrNext;
            r_haltHit   <= w_haltHitNext;
            r_overflow  <= w_overflowNext;
            r_busy      <= (w_stateNext == S_RUN);
            r_done      <= (w_stateNext == S_DONE);
            r_numSteps  <= w_numStepsNext;
            r_haltPc    <= w_haltPcNext;
        end
    end

    // Trace RAM write; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (w_wrEn) begin
            r_trace[r_wrPtr] <= bus.coreResult;
        end
    end

    // Registered read port; a same-edge write to rdAddr returns old data.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_rdData <= '0;
        end else begin
            r_rdData <= r_trace[bus.rdAddr];
        end
    end

    assign bus.pcIn      = r_pcIn;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.haltHit   = r_haltHit;
    assign bus.overflow  = r_overflow;
    assign bus.stepsDone = r_stepsDone;
    assign bus.rdData    = r_rdData;

endmodule
`default_nettype wire

// File: tb/tb_mips_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_run_controller
// Description : Self-checking bench for mips_run_controller. A simple core
//               model (pcOut = pcIn + stride, result = pcIn ^ salt) closes
//               the loop; a reference model predicts each run's outcome.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_run_controller;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int SW    = 8;

    logic clk    = 1'b0;
    logic resetN = 1'b0;

    always #5 clk = ~clk;

    mips_run_controller_if #(.DATA_WIDTH(DW), .TRACE_AW(AW), .STEP_W(SW)) bus ();

    mips_run_controller #(
        .DATA_WIDTH (DW),
        .TRACE_DEPTH(DEPTH),
        .TRACE_AW   (AW),
        .STEP_W     (SW)
    ) dut (
        .clock (clk),
        .resetN(resetN),
        .bus   (bus)
    );

    // Core model
    logic [31:0] stride = 32'd4;
    logic [31:0] salt   = 32'd0;

    always_comb begin
        bus.corePcOut  = bus.pcIn + stride;
        bus.coreResult = bus.pcIn ^ salt;
    end

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] mtrace [DEPTH];
    bit          mvalid [DEPTH];
    int          e_steps;
    logic [31:0] e_pc;
    bit          e_hit;
    bit          e_ov;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Walk the instruction stream the way the host loop would: record each
    // result, advance the PC, stop on halt PC or after n instructions.
    task automatic model_run(input logic [31:0] spc, input int n, input logic [31:0] hpc);
        logic [31:0] pc;
        int          idx;
        pc      = spc;
        e_steps = 0;
        e_hit   = 1'b0;
        e_ov    = 1'b0;
        if (n != 0) begin
            while (1) begin
                idx = (e_steps < DEPTH) ? e_steps : DEPTH - 1;
                if (e_steps >= DEPTH) e_ov = 1'b1;
                mtrace[idx] = pc ^ salt;
                mvalid[idx] = 1'b1;
                e_steps++;
                pc = pc + stride;
                if (pc == hpc) begin
                    e_hit = 1'b1;
                    break;
                end
                if (e_steps == n) break;
            end
        end
        e_pc = pc;
    endtask

    task automatic launch(input logic [31:0] spc, input int n, input logic [31:0] hpc,
                          input bit with_abort);
        bus.startPc  = spc;
        bus.numSteps = SW'(n);
        bus.haltPc   = hpc;
        bus.abort    = with_abort;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int addr, input logic [31:0] exp);
        bus.rdAddr = AW'(addr);
        tick();
        chk(tag, 64'(bus.rdData), 64'(exp));
    endtask

    task automatic check_trace(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            if (mvalid[i]) rd_chk($sformatf("%s_trace[%0d]", tag, i), i, mtrace[i]);
        end
    endtask

    task automatic run_and_check(input string tag, input logic [31:0] spc, input int n,
                                 input logic [31:0] hpc, input bit with_abort);
        int cyc;
        cyc = 0;
        model_run(spc, n, hpc);
        launch(spc, n, hpc, with_abort);
        while (bus.busy === 1'b1 && cyc < 300) begin
            cyc++;
            tick();
        end
        chk({tag, "_busy_cycles"}, 64'(cyc), 64'(e_steps));
        chk({tag, "_done"},        64'(bus.done), 64'd1);
        chk({tag, "_busy"},        64'(bus.busy), 64'd0);
        chk({tag, "_stepsDone"},   64'(bus.stepsDone), 64'(e_steps));
        chk({tag, "_pcIn"},        64'(bus.pcIn), 64'(e_pc));
        chk({tag, "_haltHit"},     64'(bus.haltHit), 64'(e_hit));
        chk({tag, "_overflow"},    64'(bus.overflow), 64'(e_ov));
        check_trace(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mvalid[i] = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.startPc  = '0;
        bus.numSteps = '0;
        bus.haltPc   = '0;
        bus.rdAddr   = '0;

        // Reset state
        resetN = 1'b0;
        tick();
        tick();
        chk("rst_busy",      64'(bus.busy), 64'd0);
        chk("rst_done",      64'(bus.done), 64'd0);
        chk("rst_pcIn",      64'(bus.pcIn), 64'd0);
        chk("rst_stepsDone", 64'(bus.stepsDone), 64'd0);
        chk("rst_haltHit",   64'(bus.haltHit), 64'd0);
        chk("rst_overflow",  64'(bus.overflow), 64'd0);
        chk("rst_rdData",    64'(bus.rdData), 64'd0);
        resetN = 1'b1;
        tick();

        // Count-limited run
        run_and_check("basic", 32'h0, 5, 32'hFFFF_FFFF, 1'b0);

        // Halt-PC run
        run_and_check("halt", 32'h100, 50, 32'h10C, 1'b0);

        // Overflowing run
        run_and_check("ovf", 32'h0, 40, 32'hFFFF_FFFF, 1'b0);
        rd_chk("ovf_last", 31, 32'd156);
        rd_chk("ovf_prev", 30, 32'd120);

        // Exactly full trace does not overflow
        run_and_check("full", 32'h0, 32, 32'hFFFF_FFFF, 1'b0);
        run_and_check("ovf2", 32'h0, 40, 32'hFFFF_FFFF, 1'b0);

        // Abort on the third RUN cycle, with a start pulse during RUN
        salt = 32'hA5A5_0000;
        launch(32'h0, 10, 32'hFFFF_FFFF, 1'b0);
        tick();                               // step 1
        bus.startPc  = 32'h500;
        bus.numSteps = SW'(1);
        bus.start    = 1'b1;
        tick();                               // step 2, start ignored
        bus.start    = 1'b0;
        bus.abort    = 1'b1;
        tick();                               // abort edge
        bus.abort    = 1'b0;
        chk("abort_done",      64'(bus.done), 64'd1);
        chk("abort_busy",      64'(bus.busy), 64'd0);
        chk("abort_stepsDone", 64'(bus.stepsDone), 64'd2);
        chk("abort_pcIn",      64'(bus.pcIn), 64'd8);
        chk("abort_haltHit",   64'(bus.haltHit), 64'd0);
        mtrace[0] = 32'h0 ^ salt;
        mtrace[1] = 32'h4 ^ salt;
        rd_chk("abort_trace0", 0, mtrace[0]);
        rd_chk("abort_trace1", 1, mtrace[1]);
        rd_chk("abort_trace2_unwritten", 2, 32'd8);

        // abort alone in DONE is ignored
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_idle_done",      64'(bus.done), 64'd1);
        chk("abort_idle_stepsDone", 64'(bus.stepsDone), 64'd2);

        // Zero-step run
        salt = 32'h0;
        run_and_check("zero", 32'h40, 0, 32'hFFFF_FFFF, 1'b0);

        // start with abort in DONE: start wins
        run_and_check("start_abort", 32'h200, 3, 32'hFFFF_FFFF, 1'b1);

        // Reset mid-run at stepsDone=3
        launch(32'h0, 10, 32'hFFFF_FFFF, 1'b0);
        tick();
        tick();
        tick();
        chk("midrst_pre_steps", 64'(bus.stepsDone), 64'd3);
        resetN = 1'b0;
        #1;
        chk("midrst_busy",  64'(bus.busy), 64'd0);
        chk("midrst_done",  64'(bus.done), 64'd0);
        chk("midrst_pcIn",  64'(bus.pcIn), 64'd0);
        chk("midrst_steps", 64'(bus.stepsDone), 64'd0);
        tick();
        resetN = 1'b1;
        tick();
        run_and_check("after_rst", 32'h0, 5, 32'hFFFF_FFFF, 1'b0);

        // Read latency: new address shows up only after the next edge
        rd_chk("lat_addr1", 1, 32'd4);
        bus.rdAddr = AW'(3);
        #1;
        chk("lat_hold", 64'(bus.rdData), 64'd4);
        tick();
        chk("lat_addr3", 64'(bus.rdData), 64'd12);

        // Randomized runs
        for (int r = 0; r < 12; r++) begin
            logic [31:0] spc;
            logic [31:0] hpc;
            int          n;
            stride = 32'($urandom_range(1, 8)) * 32'd4;
            salt   = $urandom;
            spc    = $urandom & 32'hFFFF_FFFC;
            n      = int'($urandom_range(0, 60));
            if ($urandom_range(0, 1) == 1)
                hpc = spc + stride * 32'($urandom_range(1, 70));
            else
                hpc = spc - stride;
            run_and_check($sformatf("rnd%0d", r), spc, n, hpc, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_run_controller.md
Name: mips_run_controller

Overview:
Hardware replacement for the bench-side stepping loop around mips_core. Owns the PC register driving the core's pcIn and feeds the core's pcOut back each cycle. Captures the core's result into a trace buffer. Stops after a programmed step count, at a halt PC, or on abort; trace contents are then read back through a registered read port.

Parameters:
DATA_WIDTH, 32, width of PC and result
TRACE_DEPTH, 32, trace buffer entries (power of two)
TRACE_AW, 5, trace address width, log2(TRACE_DEPTH)
STEP_W, 8, width of step counter and step limit

Ports:
clock  input  1  single clock, rising edge
resetN  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; launches a run from IDLE or DONE
abort  input  1  ends a run in progress
startPc  input  DATA_WIDTH  PC loaded on start
numSteps  input  STEP_W  instructions to execute; sampled on start
haltPc  input  DATA_WIDTH  run stops after the step whose pcOut equals this; sampled on start
pcIn  output  DATA_WIDTH  registered PC to mips_core pcIn
corePcOut  input  DATA_WIDTH  mips_core pcOut
coreResult  input  DATA_WIDTH  mips_core result
busy  output  1  high in RUN
done  output  1  high in DONE
haltHit  output  1  run ended on haltPc match
overflow  output  1  sticky; more steps executed than TRACE_DEPTH
stepsDone  output  STEP_W  steps executed in current or last run
rdAddr  input  TRACE_AW  trace read address
rdData  output  DATA_WIDTH  trace[rdAddr], one-cycle latency

Behaviour:
- Reset (async, resetN=0): state IDLE; pcIn=0; busy=0; done=0; haltHit=0; overflow=0; stepsDone=0; wrPtr=0; rdData=0. Trace RAM contents are not reset.
- States: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE); both registered.
- IDLE/DONE with start=1:
  - latch numSteps and haltPc; pcIn<=startPc.
  - clear stepsDone, wrPtr, haltHit and overflow.
  - numSteps==0 -> DONE directly, no trace writes; else RUN.
- RUN, each rising edge, step k = the edge on which stepsDone goes k-1 -> k:
  - trace[wrPtr]<=coreResult, for the instruction currently at pcIn.
  - pcIn<=corePcOut; stepsDone++.
  - wrPtr++ until wrPtr==TRACE_DEPTH-1; after that, writes go to the last entry and overflow<=1.
- RUN exit, checked on the same edge as the step:
  - corePcOut==haltPc -> DONE with haltHit<=1; the step is still recorded and pcIn updated.
  - else stepsDone+1==numSteps -> DONE.
  - Halt match and count exhaustion on the same edge -> DONE with haltHit=1.
- abort in RUN: DONE on that edge. No trace write, no pcIn update, no stepsDone increment. abort has priority over the step.
- start during RUN is ignored. abort in IDLE/DONE is ignored. start and abort together in IDLE/DONE: start wins.
- DONE holds pcIn, stepsDone and flags until the next start.
- Read port:
  - rdData<=trace[rdAddr] every cycle, in any state.
  - A read of the address being written on the same edge returns the old contents.
  - Reads at or beyond stepsDone return stale data. This is allowed.
- Arithmetic: PC is passed through unmodified, with no wrap checks. stepsDone saturates at 2^STEP_W-1 (only reachable with numSteps=0 semantics disabled; not otherwise reachable).
- resetN asserted mid-run returns to IDLE immediately; the run is lost.

Test Plan:
- Reset, then start with startPc=0, numSteps=5, haltPc=0xFFFFFFFF, core model pcOut=pcIn+4 and result=pcIn -> busy for 5 cycles; done=1; stepsDone=5; pcIn=20; trace[0..4]=0,4,8,12,16; haltHit=0.
- startPc=0x100, numSteps=50, haltPc=0x10C -> done after 3 steps; haltHit=1; pcIn=0x10C; trace[0..2]=0x100,0x104,0x108.
- numSteps=40 with TRACE_DEPTH=32 -> overflow=1; stepsDone=40; trace[31]=result of step 40 (156); trace[30]=120.
- abort on the 3rd RUN cycle of a numSteps=10 run -> done next edge; stepsDone=2; pcIn=8; trace[2] unwritten. A start pulse during RUN has no effect.
- numSteps=0 -> busy never high; done=1 one cycle after start; pcIn=startPc; stepsDone=0.
- resetN low for 1 cycle mid-run at stepsDone=3 -> immediately busy=0, done=0, pcIn=0. A following start runs normally. Check rdData latency: rdAddr=1 -> rdData=4 on the next edge.
